// File: rtl/my_nios_mul_pkg.sv
// Shared types for the sequential Nios II multiplier: op codes, FSM states, half-width helper.
// High-half support is enabled by defining MY_NIOS_MUL_HIGH_EN.
package my_nios_mul_pkg;

   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULXUU = 2'd1,
      OP_MULXSU = 2'd2,
      OP_MULXSS = 2'd3
   } mul_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PP0  = 3'd1,
      ST_PP1  = 3'd2,
      ST_PP2  = 3'd3,
      ST_PP3  = 3'd4,
      ST_FIX  = 3'd5,
      ST_DONE = 3'd6
   } mul_state_e;

   function automatic int half_width(input int w);
      return w / 2;
   endfunction

endpackage

// File: rtl/my_nios_mul_slice.sv
// Combinational HxH unsigned slice multiplier shared by every partial product.
module my_nios_mul_slice #(
   parameter int H = 16
) (
   input  logic [H-1:0]   a,
   input  logic [H-1:0]   b,
   output logic [2*H-1:0] p
);

   assign p = {{H{1'b0}}, a} * {{H{1'b0}}, b};

endmodule

// File: rtl/my_nios_cpu_mul_seq.sv
// Iterative multiplier: one HxH slice walks the four partial products into an accumulator.
// Define MY_NIOS_MUL_HIGH_EN to add the high-half ops (PP3/FIX states, 2*WIDTH accumulator).
module my_nios_cpu_mul_seq
   import my_nios_mul_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             busy
);

   localparam int H = half_width(WIDTH);
`ifdef MY_NIOS_MUL_HIGH_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   mul_state_e       state;
   mul_op_e          op_q;
   logic [WIDTH-1:0] src1_q;
   logic [WIDTH-1:0] src2_q;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_next;
   logic [ACC_W-1:0] prod_ext;
   logic [WIDTH-1:0] result_q;
   logic [H-1:0]     slice_a;
   logic [H-1:0]     slice_b;
   logic [WIDTH-1:0] prod;

   // Operand halves for the slice are chosen by which partial product is in progress.
   always_comb begin
      slice_a = src1_q[H-1:0];
      slice_b = src2_q[H-1:0];
      case (state)
         ST_PP1: slice_b = src2_q[WIDTH-1:H];
         ST_PP2: slice_a = src1_q[WIDTH-1:H];
         ST_PP3: begin
            slice_a = src1_q[WIDTH-1:H];
            slice_b = src2_q[WIDTH-1:H];
         end
         default: ;
      endcase
   end

   my_nios_mul_slice #(.H(H)) u_slice (
      .a (slice_a),
      .b (slice_b),
      .p (prod)
   );

   assign prod_ext = ACC_W'(prod);

   always_comb begin
      acc_next = acc;
      case (state)
         ST_PP0:         acc_next = acc + prod_ext;
         ST_PP1, ST_PP2: acc_next = acc + (prod_ext << H);
`ifdef MY_NIOS_MUL_HIGH_EN
         ST_PP3:         acc_next = acc + (prod_ext << WIDTH);
`endif
         default: ;
      endcase
   end

`ifdef MY_NIOS_MUL_HIGH_EN
   logic [WIDTH-1:0] hi_u;
   logic [WIDTH-1:0] corr_a;
   logic [WIDTH-1:0] corr_b;
   logic [WIDTH-1:0] fix_result;

   // Signed high halves are the unsigned high half minus the sign-weighted opposite operand.
   always_comb begin
      hi_u   = acc[2*WIDTH-1:WIDTH];
      corr_a = src1_q[WIDTH-1] ? src2_q : '0;
      corr_b = src2_q[WIDTH-1] ? src1_q : '0;
      case (op_q)
         OP_MULXSU: fix_result = hi_u - corr_a;
         OP_MULXSS: fix_result = hi_u - corr_a - corr_b;
         default:   fix_result = hi_u;
      endcase
   end
`endif

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         state    <= ST_IDLE;
         op_q     <= OP_MUL;
         src1_q   <= '0;
         src2_q   <= '0;
         acc      <= '0;
         result_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q   <= mul_op_e'(in_op);
                  src1_q <= in_src1;
                  src2_q <= in_src2;
                  acc    <= '0;
                  state  <= ST_PP0;
               end
            end
            ST_PP0: begin
               acc   <= acc_next;
               state <= ST_PP1;
            end
            ST_PP1: begin
               acc   <= acc_next;
               state <= ST_PP2;
            end
            ST_PP2: begin
               acc <= acc_next;
`ifdef MY_NIOS_MUL_HIGH_EN
               if (op_q == OP_MUL) begin
                  result_q <= acc_next[WIDTH-1:0];
                  state    <= ST_DONE;
               end else begin
                  state <= ST_PP3;
               end
`else
               result_q <= (op_q == OP_MUL) ? acc_next[WIDTH-1:0] : '0;
               state    <= ST_DONE;
`endif
            end
`ifdef MY_NIOS_MUL_HIGH_EN
            ST_PP3: begin
               acc   <= acc_next;
               state <= ST_FIX;
            end
            ST_FIX: begin
               result_q <= fix_result;
               state    <= ST_DONE;
            end
`endif
            ST_DONE: begin
               if (out_ready) begin
                  result_q <= '0;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready   = (state == ST_IDLE) && reset_n;
   assign busy       = (state != ST_IDLE);
   assign out_valid  = (state == ST_DONE);
   assign out_result = result_q;

endmodule

// File: tb/tb_my_nios_cpu_mul_seq.sv
// Self-checking bench for my_nios_cpu_mul_seq (WIDTH=32); adapts to MY_NIOS_MUL_HIGH_EN.
module tb_my_nios_cpu_mul_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_op = 2'd0;
   logic [31:0] in_src1 = '0;
   logic [31:0] in_src2 = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_result;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // Reference model state: cycles left until result, result pending/presented.
   logic        model_ready = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_valid = 1'b0;
   int          m_count = 0;
   logic [31:0] m_pending = '0;
   logic [31:0] m_result = '0;

`ifdef MY_NIOS_MUL_HIGH_EN
   localparam int          HI_LAT = 6;
   localparam logic [31:0] EXP_UU = 32'hFFFF_FFFE;
   localparam logic [31:0] EXP_SS = 32'h0000_0000;
   localparam logic [31:0] EXP_SU = 32'hFFFF_FFFF;
`else
   localparam int          HI_LAT = 4;
   localparam logic [31:0] EXP_UU = 32'h0;
   localparam logic [31:0] EXP_SS = 32'h0;
   localparam logic [31:0] EXP_SU = 32'h0;
`endif

   my_nios_cpu_mul_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] pu;
      longint      ps;
      pu = {32'b0, a} * {32'b0, b};
      ps = 0;
      case (op)
         2'd0: return pu[31:0];
`ifdef MY_NIOS_MUL_HIGH_EN
         2'd1: return pu[63:32];
         2'd2: begin
            ps = longint'($signed(a)) * longint'({32'b0, b});
            return ps[63:32];
         end
         default: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            return ps[63:32];
         end
`else
         default: return 32'h0;
`endif
      endcase
   endfunction

   function automatic int refLatency(input logic [1:0] op);
`ifdef MY_NIOS_MUL_HIGH_EN
      return (op == 2'd0) ? 4 : 6;
`else
      return (op == 2'd0) ? 4 : 4;
`endif
   endfunction

   // Transaction-level model: accept in idle, present result after the op's latency, hold until taken.
   always @(posedge clk) begin
      model_ready = 1'b1;
      if (!reset_n || flush) begin
         m_busy   = 1'b0;
         m_valid  = 1'b0;
         m_count  = 0;
         m_result = '0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid  = 1'b0;
            m_result = '0;
         end
      end else if (m_busy) begin
         m_count = m_count - 1;
         if (m_count == 0) begin
            m_busy   = 1'b0;
            m_valid  = 1'b1;
            m_result = m_pending;
         end
      end else if (in_valid) begin
         m_busy    = 1'b1;
         m_count   = refLatency(in_op) - 1;
         m_pending = refResult(in_op, in_src1, in_src2);
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Every bench wait goes through here so DUT outputs are compared with the model each cycle.
   task automatic tick();
      @(negedge clk);
      if (model_ready) begin
         checkOutput("cyc_out_valid", 64'(out_valid), 64'(m_valid));
         checkOutput("cyc_out_result", 64'(out_result), 64'(m_result));
         checkOutput("cyc_in_ready", 64'(in_ready), 64'(reset_n && !m_busy && !m_valid));
         checkOutput("cyc_busy", 64'(busy), 64'(m_busy || m_valid));
      end
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output int lat, output logic [31:0] res);
      tick();
      #1;
      in_op    = op;
      in_src1  = a;
      in_src2  = b;
      in_valid = 1'b1;
      lat      = -1;
      res      = '0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (out_valid && lat < 0) begin
            lat = c;
            res = out_result;
         end
         if (c == 1) begin
            #1;
            in_valid = 1'b0;
         end
         if (lat >= 0) break;
      end
   endtask

   initial begin
      int          lat;
      logic [31:0] res;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        seen_valid;

      $display("[TB] start");
      repeat (3) tick();
      checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
      checkOutput("rst_out_result", 64'(out_result), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_in_ready_low", 64'(in_ready), 64'd0);
      #1 reset_n = 1'b1;
      tick();
      checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

      applyStimulus(2'd0, 32'h0001_0003, 32'h0002_0005, lat, res);
      checkOutput("mul_res", 64'(res), 64'h000B_000F);
      checkOutput("mul_lat", 64'(lat), 64'd4);

      applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
      checkOutput("mulxuu_res", 64'(res), 64'(EXP_UU));
      checkOutput("mulxuu_lat", 64'(lat), 64'(HI_LAT));
      applyStimulus(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
      checkOutput("mulxss_res", 64'(res), 64'(EXP_SS));
      checkOutput("mulxss_lat", 64'(lat), 64'(HI_LAT));
      applyStimulus(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
      checkOutput("mulxsu_res", 64'(res), 64'(EXP_SU));
      applyStimulus(2'd0, 32'h0000_00FF, 32'h0000_0101, lat, res);
      checkOutput("mul_ff_res", 64'(res), 64'h0000_FFFF);

      // Backpressure: hold DONE for three cycles while offering a new op.
      tick();
      #1;
      in_op = 2'd0; in_src1 = 32'd1234; in_src2 = 32'd5678; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      #1 in_valid = 1'b0;
      for (int c = 0; c < 12 && !out_valid; c++) tick();
      checkOutput("bp_valid", 64'(out_valid), 64'd1);
      for (int i = 0; i < 3; i++) begin
         #1;
         in_valid = 1'b1; in_src1 = 32'd9; in_src2 = 32'd9;
         tick();
         checkOutput("bp_hold_res", 64'(out_result), 64'd7006652);
         checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      end
      #1;
      out_ready = 1'b1; in_valid = 1'b0;
      tick();
      checkOutput("bp_release_valid", 64'(out_valid), 64'd0);
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);

      // Flush while PP1 is in progress.
      #1;
      in_op = 2'd0; in_src1 = 32'd77; in_src2 = 32'd88; in_valid = 1'b1;
      tick();
      #1 in_valid = 1'b0;
      tick();
      #1 flush = 1'b1;
      tick();
      checkOutput("flush_busy", 64'(busy), 64'd0);
      checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
      #1 flush = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (out_valid) seen_valid = 1'b1;
      end
      checkOutput("flush_no_valid", 64'(seen_valid), 64'd0);

      // Reset asserted four cycles after accept.
      #1;
      in_op = 2'd3; in_src1 = 32'h8000_0001; in_src2 = 32'h1234_5678; in_valid = 1'b1;
      tick();
      #1 in_valid = 1'b0;
      repeat (3) tick();
      #1 reset_n = 1'b0;
      tick();
      checkOutput("rstpp3_valid", 64'(out_valid), 64'd0);
      checkOutput("rstpp3_result", 64'(out_result), 64'd0);
      checkOutput("rstpp3_busy", 64'(busy), 64'd0);
      #1 reset_n = 1'b1;
      tick();
      checkOutput("rstpp3_in_ready", 64'(in_ready), 64'd1);

      // Flush and in_valid together while idle.
      #1;
      flush = 1'b1; in_valid = 1'b1; in_op = 2'd0; in_src1 = 32'd5; in_src2 = 32'd6;
      tick();
      checkOutput("flushvalid_ready", 64'(in_ready), 64'd1);
      checkOutput("flushvalid_busy", 64'(busy), 64'd0);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      repeat (5) tick();
      checkOutput("flushvalid_no_out", 64'(out_valid), 64'd0);

      // Random back-to-back ops checked against the reference functions.
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         applyStimulus(rop, ra, rb, lat, res);
         checkOutput("rand_res", 64'(res), 64'(refResult(rop, ra, rb)));
         checkOutput("rand_lat", 64'(lat), 64'(refLatency(rop)));
      end

      // Random valid/ready/flush traffic, checked cycle by cycle against the model.
      for (int n = 0; n < 400; n++) begin
         #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_op     = 2'($urandom_range(0, 3));
         in_src1   = $urandom;
         in_src2   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         tick();
      end
      #1;
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (10) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
